// File: rtl/wts_timer_source_pkg.sv
// wts_timer_source_pkg: event address codes and default widths shared by the WTS timer,
// interrupt/status block and register file.
package wts_timer_source_pkg;
  localparam int WTS_PERIOD_W_DEF = 16;
  localparam int WTS_PRESCALE_W_DEF = 8;
  typedef logic [1:0] wts_tadr_t;
  localparam wts_tadr_t WTS_TADR_Q1 = 2'd0;
  localparam wts_tadr_t WTS_TADR_Q2 = 2'd1;
  localparam wts_tadr_t WTS_TADR_Q3 = 2'd2;
  localparam wts_tadr_t WTS_TADR_WRAP = 2'd3;
endpackage

// File: rtl/wts_timer_prescaler.sv
// wts_timer_prescaler: divides clk into ticks every reg_prescale+1 clocks while running.
// reg_prescale is compared live, so a change applies at the next compare.
module wts_timer_prescaler
  import wts_timer_source_pkg::*;
#(
  parameter int PRESCALE_W = WTS_PRESCALE_W_DEF
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  running,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] reg_prescale,
  output logic                  tick
);
  logic [PRESCALE_W-1:0] pre;
  assign tick = running && pre == reg_prescale;
  always_ff @(posedge clk)
    if (!nreset || clear) pre <= '0;
    else if (running) pre <= tick ? '0 : pre + 1'b1;
endmodule

// File: rtl/wts_timer_source.sv
// wts_timer_source: prescaled period timer emitting quarter-point and wrap trigger events.
// Define WTS_TIMER_ONESHOT_EN to add reg_oneshot (stop after the first wrap event).
module wts_timer_source
  import wts_timer_source_pkg::*;
#(
  parameter int PERIOD_W   = WTS_PERIOD_W_DEF,
  parameter int PRESCALE_W = WTS_PRESCALE_W_DEF
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic [PERIOD_W-1:0]   reg_period,
  input  logic [PRESCALE_W-1:0] reg_prescale,
  input  logic [3:0]            reg_mask,
  input  logic                  reg_start,
  input  logic                  reg_stop,
`ifdef WTS_TIMER_ONESHOT_EN
  input  logic                  reg_oneshot,
`endif
  output logic                  timer_trigger,
  output logic [1:0]            timer_address,
  output logic                  timer_running,
  output logic [PERIOD_W-1:0]   timer_count
);
  localparam logic [PERIOD_W+1:0] ONE = {{(PERIOD_W+1){1'b0}}, 1'b1};
  logic [PERIOD_W-1:0] shadow, q;
  logic [PERIOD_W+1:0] c_ext, q_ext, q1, q2, q3;
  logic tick, start, wrap, q_hit, ev_hit;
  wts_tadr_t ev_addr;
  assign start = reg_start && !reg_stop;
  wts_timer_prescaler #(.PRESCALE_W(PRESCALE_W)) u_pre (
    .clk(clk),
    .nreset(nreset),
    .running(timer_running && !reg_stop),
    .clear(start),
    .reg_prescale(reg_prescale),
    .tick(tick)
  );
  // Quarter points are computed two bits wider so 3q-1 cannot overflow.
  always_comb begin
    c_ext = {2'b00, timer_count};
    q_ext = {2'b00, q};
    q1 = q_ext - ONE;
    q2 = (q_ext << 1) - ONE;
    q3 = q_ext + (q_ext << 1) - ONE;
    wrap = timer_count == shadow;
    q_hit = q != '0 && (c_ext == q1 || c_ext == q2 || c_ext == q3);
    ev_hit = wrap || q_hit;
    ev_addr = wrap ? WTS_TADR_WRAP : c_ext == q1 ? WTS_TADR_Q1 : c_ext == q2 ? WTS_TADR_Q2 : WTS_TADR_Q3;
  end
  always_ff @(posedge clk)
    if (!nreset) begin
      timer_trigger <= 1'b0;
      timer_address <= 2'd0;
      timer_running <= 1'b0;
      timer_count <= '0;
      shadow <= '0;
      q <= '0;
    end else begin
      timer_trigger <= 1'b0;
      if (reg_stop) timer_running <= 1'b0;
      else if (start) begin
        timer_running <= 1'b1;
        timer_count <= '0;
        shadow <= reg_period;
        q <= reg_period >> 2;
      end else if (tick) begin
        timer_count <= wrap ? '0 : timer_count + 1'b1;
        if (wrap) begin
          shadow <= reg_period;
          q <= reg_period >> 2;
        end
        if (ev_hit && reg_mask[ev_addr]) begin
          timer_trigger <= 1'b1;
          timer_address <= ev_addr;
        end
`ifdef WTS_TIMER_ONESHOT_EN
        if (wrap && reg_oneshot) timer_running <= 1'b0;
`endif
      end
    end
endmodule

// File: tb/tb_wts_timer_source.sv
// tb_wts_timer_source: scoreboard bench; expected trigger cycle/address pairs are queued
// when a run is started and popped as the DUT raises timer_trigger.
module tb_wts_timer_source;
  logic clk = 1'b0;
  logic nreset = 1'b0;
  logic [15:0] reg_period = '0;
  logic [7:0] reg_prescale = '0;
  logic [3:0] reg_mask = '0;
  logic reg_start = 1'b0;
  logic reg_stop = 1'b0;
`ifdef WTS_TIMER_ONESHOT_EN
  logic reg_oneshot = 1'b0;
`endif
  logic timer_trigger, timer_running;
  logic [1:0] timer_address;
  logic [15:0] timer_count;
  typedef struct {
    int cyc;
    logic [1:0] addr;
  } exp_t;
  exp_t exp_q[$];
  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  int last_addr = 0;
  wts_timer_source dut (
    .clk(clk),
    .nreset(nreset),
    .reg_period(reg_period),
    .reg_prescale(reg_prescale),
    .reg_mask(reg_mask),
    .reg_start(reg_start),
    .reg_stop(reg_stop),
`ifdef WTS_TIMER_ONESHOT_EN
    .reg_oneshot(reg_oneshot),
`endif
    .timer_trigger(timer_trigger),
    .timer_address(timer_address),
    .timer_running(timer_running),
    .timer_count(timer_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk)
    if (timer_trigger) begin : mon
      exp_t e;
      if (exp_q.size() == 0) chk("spurious_trig", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("trig_cyc", cyc, e.cyc);
        chk("trig_addr", timer_address, e.addr);
      end
    end
  function automatic int ev(int c, int sh);
    int qq = sh / 4;
    if (c == sh) return 3;
    if (qq != 0 && c == qq - 1) return 0;
    if (qq != 0 && c == 2 * qq - 1) return 1;
    if (qq != 0 && c == 3 * qq - 1) return 2;
    return -1;
  endfunction
  // Ticks land at s+1+p+k*(p+1); each trigger shows one cycle after its tick.
  task automatic predict(input int s, input int p, input int per0, input int per1,
                         input logic [3:0] m, input int ncyc, output int cnt_f);
    int cnt = 0;
    int sh = per0;
    int a;
    for (int ct = s + 1 + p; ct <= s + ncyc - 1; ct += p + 1) begin
      a = ev(cnt, sh);
      if (a >= 0 && m[a]) begin
        exp_q.push_back('{ct + 1, a[1:0]});
        last_addr = a;
      end
      if (cnt == sh) begin
        cnt = 0;
        sh = per1;
      end else cnt++;
    end
    cnt_f = cnt;
  endtask
  task automatic phase(input int p, input int per0, input int per1, input logic [3:0] m,
                       input int ncyc, input int chg, output int cnt_f);
    int s;
    reg_prescale = 8'(p);
    reg_period = 16'(per0);
    reg_mask = m;
    reg_start = 1'b1;
    s = cyc;
    predict(s, p, per0, per1, m, ncyc, cnt_f);
    step();
    reg_start = 1'b0;
    @(negedge clk);
    chk("start_run", timer_running, 1);
    chk("start_cnt", timer_count, 0);
    for (int i = 2; i <= ncyc; i++) begin
      step();
      if (i == chg) reg_period = 16'(per1);
    end
    reg_stop = 1'b1;
    step();
    reg_stop = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("stop_run", timer_running, 0);
    chk("stop_cnt", timer_count, cnt_f);
    chk("pending", exp_q.size(), 0);
    chk("hold_addr", timer_address, last_addr);
  endtask
  initial begin
    int cf;
    int s;
    reg_start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_trig", timer_trigger, 0);
      chk("rst_addr", timer_address, 0);
      chk("rst_run", timer_running, 0);
      chk("rst_cnt", timer_count, 0);
    end
    step();
    nreset = 1'b1;
    reg_start = 1'b0;
    step();
    phase(0, 7, 7, 4'hF, 40, 0, cf);
    phase(3, 3, 3, 4'b1000, 70, 0, cf);
    phase(0, 15, 3, 4'hF, 40, 6, cf);
    phase(0, 15, 15, 4'hF, 5, 0, cf);
    repeat (10) step();
    @(negedge clk);
    chk("held_cnt", timer_count, 4);
    step();
    reg_start = 1'b1;
    reg_stop = 1'b1;
    step();
    reg_start = 1'b0;
    reg_stop = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("both_run", timer_running, 0);
    chk("both_cnt", timer_count, 4);
    phase(0, 15, 15, 4'hF, 20, 0, cf);
    reg_prescale = 8'd0;
    reg_period = 16'd3;
    reg_mask = 4'hF;
    reg_start = 1'b1;
    step();
    reg_start = 1'b0;
    repeat (3) step();
    nreset = 1'b0;
    step();
    @(negedge clk);
    chk("abort_trig", timer_trigger, 0);
    chk("abort_run", timer_running, 0);
    chk("abort_cnt", timer_count, 0);
    nreset = 1'b1;
    last_addr = 0;
    step();
`ifdef WTS_TIMER_ONESHOT_EN
    reg_oneshot = 1'b1;
    reg_start = 1'b1;
    s = cyc;
    exp_q.push_back('{s + 5, 2'd3});
    step();
    reg_start = 1'b0;
    repeat (20) step();
    @(negedge clk);
    chk("os_run", timer_running, 0);
    chk("os_cnt", timer_count, 0);
    chk("os_pending", exp_q.size(), 0);
    reg_oneshot = 1'b0;
`endif
    s = cyc;
    chk("no_pending", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
